lcd_pattern_gen: RTL and testbench

Parametrised RGB test-pattern generator for the parallel-RGB LCD path. It sits between the LCD timing generator and the panel output register. It takes the current pixel coordinate, data-enable and a frame-start pulse, and produces a registered RGB word. Selectable modes: colour bars, checkerboard, greyscale ramp and an animated bouncing box. Mode changes are frame-synchronous.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_pattern_gen_box_mover.sv | 84 ++++++++
 rtl/lcd_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD test-pattern generator: pattern modes and
// width-independent colour codes (one on/off flag per R, G, B channel).
package lcd_pkg;

    typedef enum logic [2:0] {
        MODE_BARS  = 3'd0,
        MODE_CHECK = 3'd1,
        MODE_RAMP  = 3'd2,
        MODE_BOX   = 3'd3
    } mode_e;

    // Colour codes {R,G,B}; each set bit expands to a full channel.
    localparam logic [2:0] WHITE   = 3'b111;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] BLACK   = 3'b000;

    // Colour of vertical bar number idx, left to right.
    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_pattern_gen_box_mover.sv
// Bouncing-box position state, advanced once per frame_start pulse.
module lcd_box_mover #(
    parameter int H_DISPLAY = 480,
    parameter int V_DISPLAY = 272,
    parameter int BOX_SIZE  = 32,
    parameter int X_W       = 11,
    parameter int Y_W       = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           step_i,
    output logic [X_W-1:0] bx_o,
    output logic [Y_W-1:0] by_o,
    output logic           dir_x_o,
    output logic           dir_y_o
);

    localparam logic [X_W-1:0] X_LIM = X_W'(H_DISPLAY - BOX_SIZE);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(V_DISPLAY - BOX_SIZE);

    logic [X_W-1:0] bx_q, bx_d;
    logic [Y_W-1:0] by_q, by_d;
    logic           dir_x_q, dir_x_d;   // 1 = moving +
    logic           dir_y_q, dir_y_d;

    // Next position: bounce at either edge by reversing and stepping back.
    always_comb begin
        bx_d    = bx_q;
        by_d    = by_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (dir_x_q) begin
            if (bx_q == X_LIM) begin
                dir_x_d = 1'b0;
                bx_d    = bx_q - X_W'(1);
            end else begin
                bx_d    = bx_q + X_W'(1);
            end
        end else begin
            if (bx_q == '0) begin
                dir_x_d = 1'b1;
                bx_d    = bx_q + X_W'(1);
            end else begin
                bx_d    = bx_q - X_W'(1);
            end
        end
        if (dir_y_q) begin
            if (by_q == Y_LIM) begin
                dir_y_d = 1'b0;
                by_d    = by_q - Y_W'(1);
            end else begin
                by_d    = by_q + Y_W'(1);
            end
        end else begin
            if (by_q == '0) begin
                dir_y_d = 1'b1;
                by_d    = by_q + Y_W'(1);
            end else begin
                by_d    = by_q - Y_W'(1);
            end
        end
    end

    // Position registers, updated only on a frame step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx_q    <= '0;
            by_q    <= '0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else if (step_i) begin
            bx_q    <= bx_d;
            by_q    <= by_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign bx_o    = bx_q;
    assign by_o    = by_q;
    assign dir_x_o = dir_x_q;
    assign dir_y_o = dir_y_q;

endmodule

// File: rtl/lcd_pattern_gen.sv
// RGB test-pattern generator: classify the pixel in stage 1, colour it in
// stage 2. Mode and box position change only on frame_start.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_DISPLAY  = 480,
    parameter int V_DISPLAY  = 272,
    parameter int X_W        = 11,
    parameter int Y_W        = 10,
    parameter int COLOR_W    = 8,
    parameter int CHECK_LOG2 = 4,
    parameter int BOX_SIZE   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [X_W-1:0]         pixel_x,
    input  logic [Y_W-1:0]         pixel_y,
    input  logic                   de_in,
    input  logic                   frame_start,
    input  logic [2:0]             mode_sel,
    output logic [3*COLOR_W-1:0]   rgb_data,
    output logic                   de_out,
    output logic [2:0]             mode_act
);

    localparam int BAR_W = H_DISPLAY / 8;

    function automatic logic [3*COLOR_W-1:0] expand(input logic [2:0] code);
        return {{COLOR_W{code[2]}}, {COLOR_W{code[1]}}, {COLOR_W{code[0]}}};
    endfunction

    logic [2:0]     mode_q;
    logic [X_W-1:0] bx_s;
    logic [Y_W-1:0] by_s;
    logic           dir_x_s, dir_y_s;

    // stage 1
    logic           de1_q, in_range_q, checker_q, in_box_q;
    logic [2:0]     mode1_q, bar_code_q, bar_code_d;
    logic [7:0]     ramp_q;
    logic           in_range_d, in_box_d;
    // stage 2
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;
    logic                 de2_q;
    logic [COLOR_W-1:0]   ramp_c;

    lcd_box_mover #(
        .H_DISPLAY (H_DISPLAY),
        .V_DISPLAY (V_DISPLAY),
        .BOX_SIZE  (BOX_SIZE),
        .X_W       (X_W),
        .Y_W       (Y_W)
    ) u_box (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_i  (frame_start),
        .bx_o    (bx_s),
        .by_o    (by_s),
        .dir_x_o (dir_x_s),
        .dir_y_o (dir_y_s)
    );

    // Latch the requested mode only at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 3'd0;
        end else if (frame_start) begin
            mode_q <= mode_sel;
        end
    end

    // Stage-1 classification: bar colour, range and box membership.
    always_comb begin
        bar_code_d = BLACK;
        for (int i = 0; i < 8; i++) begin
            if ((pixel_x >= X_W'(i * BAR_W)) && (pixel_x < X_W'((i + 1) * BAR_W))) begin
                bar_code_d = bar_color(3'(i));
            end else begin
                bar_code_d = bar_code_d;
            end
        end
        in_range_d = (pixel_x < X_W'(H_DISPLAY)) && (pixel_y < Y_W'(V_DISPLAY));
        in_box_d   = ({1'b0, pixel_x} >= {1'b0, bx_s})
                  && ({1'b0, pixel_x} <  ({1'b0, bx_s} + (X_W+1)'(BOX_SIZE)))
                  && ({1'b0, pixel_y} >= {1'b0, by_s})
                  && ({1'b0, pixel_y} <  ({1'b0, by_s} + (Y_W+1)'(BOX_SIZE)));
    end

    // Stage-1 pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de1_q      <= 1'b0;
            in_range_q <= 1'b0;
            checker_q  <= 1'b0;
            in_box_q   <= 1'b0;
            mode1_q    <= 3'd0;
            bar_code_q <= 3'd0;
            ramp_q     <= 8'd0;
        end else begin
            de1_q      <= de_in;
            in_range_q <= in_range_d;
            checker_q  <= pixel_x[CHECK_LOG2] ^ pixel_y[CHECK_LOG2];
            in_box_q   <= in_box_d;
            mode1_q    <= mode_q;
            bar_code_q <= bar_code_d;
            ramp_q     <= pixel_x[7:0];
        end
    end

    // Ramp byte left-aligned into the channel width.
    if (COLOR_W >= 8) begin : g_ramp_wide
        assign ramp_c = COLOR_W'(ramp_q) << (COLOR_W - 8);
    end else begin : g_ramp_narrow
        assign ramp_c = ramp_q[7 -: COLOR_W];
    end

    // Stage-2 colour selection with blanking outside active video.
    always_comb begin
        rgb_d = '0;
        if (de1_q && in_range_q) begin
            case (mode1_q)
                MODE_BARS:  rgb_d = expand(bar_code_q);
                MODE_CHECK: rgb_d = checker_q ? expand(BLACK) : expand(WHITE);
                MODE_RAMP:  rgb_d = {ramp_c, ramp_c, ramp_c};
                MODE_BOX:   rgb_d = in_box_q ? expand(WHITE) : expand(BLUE);
                default:    rgb_d = expand(BLACK);
            endcase
        end else begin
            rgb_d = '0;
        end
    end

    // Stage-2 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            de2_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de2_q <= de1_q;
        end
    end

    assign rgb_data = rgb_q;
    assign de_out   = de2_q;
    assign mode_act = mode_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Scoreboard bench for lcd_pattern_gen with default parameters.
module tb_lcd_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] pixel_x = 11'd0;
    logic [9:0]  pixel_y = 10'd0;
    logic        de_in = 1'b0;
    logic        frame_start = 1'b0;
    logic [2:0]  mode_sel = 3'd0;
    logic [23:0] rgb_data;
    logic        de_out;
    logic [2:0]  mode_act;

    typedef struct {
        bit          chk;
        string       tag;
        logic        de;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference state
    int m_mode = 0;
    int m_bx = 0, m_by = 0;
    bit m_dx = 1'b1, m_dy = 1'b1;

    lcd_pattern_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .de_in       (de_in),
        .frame_start (frame_start),
        .mode_sel    (mode_sel),
        .rgb_data    (rgb_data),
        .de_out      (de_out),
        .mode_act    (mode_act)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(int x, int y, bit de, int mode, int bx, int by);
        if (!de || x >= 480 || y >= 272) return 24'h000000;
        case (mode)
            0: begin
                case (x / 60)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return ((((x >> 4) ^ (y >> 4)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
            2: return {3{8'(x & 255)}};
            3: return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 24'hFFFFFF : 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic void model_frame(int msel);
        m_mode = msel;
        if (m_dx) begin
            if (m_bx == 448) begin m_dx = 1'b0; m_bx--; end else m_bx++;
        end else begin
            if (m_bx == 0) begin m_dx = 1'b1; m_bx++; end else m_bx--;
        end
        if (m_dy) begin
            if (m_by == 240) begin m_dy = 1'b0; m_by--; end else m_by++;
        end else begin
            if (m_by == 0) begin m_dy = 1'b1; m_by++; end else m_by--;
        end
    endfunction

    // One pixel clock: compare the output due now, then drive the next input.
    task automatic step(input int x, input int y, input bit de, input bit fs,
                        input int msel, input bit chk, input string tag);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 2) begin
            e = sb.pop_front();
            if (e.chk) begin
                check_eq({e.tag, "_rgb"}, 32'(rgb_data), 32'(e.rgb));
                check_eq({e.tag, "_de"},  32'(de_out),   32'(e.de));
            end
        end
        check_eq("mode_act", 32'(mode_act), 32'(m_mode));
        pixel_x     = 11'(x);
        pixel_y     = 10'(y);
        de_in       = de;
        frame_start = fs;
        mode_sel    = 3'(msel);
        e.chk = chk;
        e.tag = tag;
        e.de  = de;
        e.rgb = model_pix(x, y, de, m_mode, m_bx, m_by);
        sb.push_back(e);
        if (fs) model_frame(msel);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 300, 1'b0, 1'b0, m_mode, 1'b1, "idle");
    endtask

    initial begin
        // power-on reset
        #12;
        check_eq("rst_rgb",  32'(rgb_data), 32'h0);
        check_eq("rst_de",   32'(de_out),   32'h0);
        check_eq("rst_mode", 32'(mode_act), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // colour bars over one full line
        step(0, 300, 1'b0, 1'b1, 0, 1'b1, "fs_bars");
        for (int x = 0; x < 480; x++) step(x, 5, 1'b1, 1'b0, 0, 1'b1, "bars");
        idle(2);

        // checkerboard
        step(0, 300, 1'b0, 1'b1, 1, 1'b1, "fs_check");
        step(15, 0, 1'b1, 1'b0, 1, 1'b1, "chk_15_0");
        step(16, 0, 1'b1, 1'b0, 1, 1'b1, "chk_16_0");
        step(16, 16, 1'b1, 1'b0, 1, 1'b1, "chk_16_16");
        step(40, 17, 1'b1, 1'b0, 1, 1'b1, "chk_40_17");
        idle(2);

        // grey ramp and output gating
        step(0, 300, 1'b0, 1'b1, 2, 1'b1, "fs_ramp");
        step(100, 3, 1'b1, 1'b0, 2, 1'b1, "ramp_100");
        step(300, 3, 1'b1, 1'b0, 2, 1'b1, "ramp_300");
        step(100, 3, 1'b0, 1'b0, 2, 1'b1, "ramp_de0");
        step(480, 3, 1'b1, 1'b0, 2, 1'b1, "ramp_x480");
        step(10, 272, 1'b1, 1'b0, 2, 1'b1, "ramp_y272");
        step(255, 3, 1'b1, 1'b0, 2, 1'b1, "ramp_255");
        idle(2);

        // mode latch: mode_sel change mid-frame must wait for frame_start
        step(0, 300, 1'b0, 1'b1, 0, 1'b1, "fs_latch");
        step(60, 5, 1'b1, 1'b0, 0, 1'b1, "latch_pre");
        step(60, 5, 1'b1, 1'b0, 1, 1'b1, "latch_hold0");
        step(120, 5, 1'b1, 1'b0, 1, 1'b1, "latch_hold1");
        step(60, 5, 1'b1, 1'b1, 1, 1'b1, "latch_fs_px");
        step(15, 0, 1'b1, 1'b0, 1, 1'b1, "latch_chk0");
        step(16, 0, 1'b1, 1'b0, 1, 1'b1, "latch_chk1");
        idle(2);

        // asynchronous reset in the middle of active video
        step(20, 20, 1'b1, 1'b0, 1, 1'b1, "pre_rst");
        step(3, 3, 1'b1, 1'b0, 1, 1'b1, "pre_rst2");
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rgb",  32'(rgb_data), 32'h0);
        check_eq("mid_rst_de",   32'(de_out),   32'h0);
        check_eq("mid_rst_mode", 32'(mode_act), 32'h0);
        sb.delete();
        m_mode = 0; m_bx = 0; m_by = 0; m_dx = 1'b1; m_dy = 1'b1;
        de_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_bx", 32'(dut.u_box.bx_o), 32'd0);
        check_eq("rst_by", 32'(dut.u_box.by_o), 32'd0);
        step(0, 0, 1'b1, 1'b0, 0, 1'b1, "post_rst_bars");
        idle(2);

        // bouncing box: 448 frames to reach the right limit
        for (int f = 0; f < 448; f++) step(0, 300, 1'b0, 1'b1, 3, 1'b0, "frames");
        idle(1);
        check_eq("box_bx448", 32'(dut.u_box.bx_o), 32'd448);
        check_eq("box_dirx_plus", 32'(dut.u_box.dir_x_o), 32'd1);
        check_eq("box_by", 32'(dut.u_box.by_o), 32'(m_by));
        step(m_bx, m_by, 1'b1, 1'b0, 3, 1'b1, "box_in");
        step(m_bx - 1, m_by, 1'b1, 1'b0, 3, 1'b1, "box_left");
        step(m_bx + 31, m_by + 31, 1'b1, 1'b0, 3, 1'b1, "box_corner");
        step(m_bx + 32, m_by, 1'b1, 1'b0, 3, 1'b1, "box_right");
        step(m_bx, m_by - 1, 1'b1, 1'b0, 3, 1'b1, "box_above");
        step(0, 300, 1'b0, 1'b1, 3, 1'b1, "fs_bounce");
        idle(1);
        check_eq("box_bx447", 32'(dut.u_box.bx_o), 32'd447);
        check_eq("box_dirx_minus", 32'(dut.u_box.dir_x_o), 32'd0);
        step(m_bx, m_by, 1'b1, 1'b0, 3, 1'b1, "box2_in");
        step(m_bx - 1, m_by, 1'b1, 1'b0, 3, 1'b1, "box2_left");
        step(479, m_by, 1'b1, 1'b0, 3, 1'b1, "box2_edge");
        idle(3);

        // solid black modes
        step(0, 300, 1'b0, 1'b1, 5, 1'b1, "fs_black");
        step(10, 10, 1'b1, 1'b0, 5, 1'b1, "black_px");
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
